regfile_fwd: RTL and testbench
==============================

Name: regfile_fwd

Overview:
Parametrised successor to the core's plain two-port register file. It adds a configurable number of read ports and a configurable number of in-pipeline forwarding sources (EX, MEM, ...). It also adds load-use hazard detection, so the ID stage gets correct operands without software NOPs. It sits beside ID in the 5-stage pipeline: WB drives the write port, later stages drive the forwarding inputs, and stall_req goes to the pipeline control.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; the file holds 2**ADDR_W entries
NUM_RD, 2, number of independent read ports
NUM_FWD, 2, number of forwarding sources; index 0 is the youngest stage (EX), higher indices are older

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  reset, asynchronous, active-high
we  in  1  WB write enable
waddr  in  ADDR_W  WB write address
wdata  in  DATA_W  WB write data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, flattened; port k occupies [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, flattened the same way
fwd_we  in  NUM_FWD  source j will write a register
fwd_waddr  in  NUM_FWD*ADDR_W  destination register of source j
fwd_wdata  in  NUM_FWD*DATA_W  result of source j
fwd_is_load  in  NUM_FWD  source j is a load whose data is not yet available
stall_req  out  1  load-use hazard; ID must hold and a bubble must be inserted

Behaviour:
- Storage: 2**ADDR_W x DATA_W array.
- While rst=1, every entry clears to 0 immediately, regardless of clk; rdata=0 and stall_req=0.
- Write: on the rising clk edge with rst=0, we=1 and waddr!=0, entry[waddr] <= wdata. Writes to address 0 are discarded, so entry 0 always reads 0.
- Read path is combinational (zero latency). For each port k, first match wins, in this order:
  1. rst=1 -> 0
  2. re[k]=0 -> 0
  3. raddr_k=0 -> 0
  4. lowest j with fwd_we[j]=1 and fwd_waddr_j=raddr_k -> fwd_wdata_j (the youngest source wins)
  5. we=1 and waddr=raddr_k -> wdata (write-through, same cycle as the write)
  6. otherwise entry[raddr_k]
- Forwarding from a source j with fwd_waddr_j=0 never occurs; address 0 is filtered in step 3.
- stall_req=1 when, for any port k, the source selected in step 4 has fwd_is_load[j]=1. rdata_k then still carries fwd_wdata_j (don't-care; the consumer is stalled).
- An older load to the same register does not raise stall_req if a younger non-load source matches first.
- Simultaneous write and read of the same address: the read returns the new data (step 5); the array updates at the edge.
- Multiple ports reading the same address resolve independently and return identical data.
- Reset asserted mid-operation: an in-flight write at that edge is lost; outputs go to 0 asynchronously.
- No X propagation: unused fwd lanes with fwd_we=0 are ignored entirely.

Decomposition:
- Shared defs package: ZeroWord, WriteEnable/WriteDisable, ReadEnable/ReadDisable, RstEnable, NOPRegAddr, plus default DATA_W/ADDR_W constants (RegBus, RegAddrBus, RegNum).
- One sub-module, regfile_rd_port: a single read port's priority mux plus its load-use match bit. It is instantiated NUM_RD times in a generate loop; the top ORs the per-port hazard bits into stall_req.

Test Plan:
- Reset/zero: assert rst while the file is loaded; write we=1, waddr=0, wdata=32'hDEADBEEF; read raddr=0 on both ports -> rdata=0, stall_req=0; after reset all 32 entries read 0.
- Write then read: write r5=32'h1234_5678, next cycle read port0 r5 -> 32'h1234_5678; port1 with re=0 -> 0.
- Write-through: same cycle, we=1, waddr=7, wdata=32'hA5A5_A5A5 and raddr0=7 -> rdata0=32'hA5A5_A5A5 before the edge.
- Forward priority: entry r9=1; WB writes r9=2; fwd[1] (MEM) r9=3; fwd[0] (EX) r9=4 -> port0 reads 4; drop fwd[0] -> 3; drop fwd[1] -> 2.
- Load-use: fwd[0] r3 with fwd_is_load=1; port1 raddr=3 -> stall_req=1; same case with fwd[0] a non-load and fwd[1] a load to r3 -> stall_req=0, rdata1=fwd_wdata_0.
- Async reset mid-write: assert rst between edges while we=1 to r12 -> r12 stays 0, rdata and stall_req drop to 0 without waiting for clk.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared definitions for the forwarding register file: default widths and
// the named constants used by the write path and every read port.
package regfile_fwd_pkg;

   localparam int RegBus     = 32;   // default register width
   localparam int RegAddrBus = 5;    // default register address width
   localparam int RegNum     = 32;   // entries at the default address width

   localparam logic [RegBus-1:0]     ZeroWord   = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;   // hard-wired zero register

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic ReadEnable   = 1'b1;
   localparam logic ReadDisable  = 1'b0;
   localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of the register file: priority mux over reset, enable,
// zero register, forwarding sources (youngest first), WB write-through and
// the stored entry, plus the load-use match bit for this port.
module regfile_rd_port
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W  = RegBus,
   parameter int ADDR_W  = RegAddrBus,
   parameter int NUM_FWD = 2
) (
   input  logic                        rst,
   input  logic                        re,
   input  logic [ADDR_W-1:0]           raddr,
   input  logic [DATA_W-1:0]           mem_data,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [NUM_FWD-1:0]          fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
   input  logic [NUM_FWD-1:0]          fwd_is_load,
   output logic [DATA_W-1:0]           rdata,
   output logic                        hazard
);

   logic fwd_hit;

   // Select the operand for this port; the first matching forwarding lane
   // (lowest index = youngest stage) wins and decides the load-use hazard.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      rdata   = DATA_W'(ZeroWord);
      hazard  = 1'b0;
      fwd_hit = 1'b0;
      if (rst != RstEnable && re == ReadEnable && raddr != ADDR_W'(NOPRegAddr)) begin
         for (int j = 0; j < NUM_FWD; j++) begin
            if (!fwd_hit && fwd_we[j] && fwd_waddr[j*ADDR_W +: ADDR_W] == raddr) begin
               fwd_hit = 1'b1;
               rdata   = fwd_wdata[j*DATA_W +: DATA_W];
               hazard  = fwd_is_load[j];
            end
         end
         if (!fwd_hit) begin
            if (we == WriteEnable && waddr == raddr) begin
               rdata = wdata;
            end else begin
               rdata = mem_data;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_fwd.sv
// Register file with NUM_RD combinational read ports, NUM_FWD in-pipeline
// forwarding sources and load-use hazard detection for the ID stage.
module regfile_fwd
   import regfile_fwd_pkg::*;
#(
   parameter int DATA_W  = RegBus,
   parameter int ADDR_W  = RegAddrBus,
   parameter int NUM_RD  = 2,
   parameter int NUM_FWD = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [NUM_RD-1:0]           re,
   input  logic [NUM_RD*ADDR_W-1:0]    raddr,
   output logic [NUM_RD*DATA_W-1:0]    rdata,
   input  logic [NUM_FWD-1:0]          fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0]   fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata,
   input  logic [NUM_FWD-1:0]          fwd_is_load,
   output logic                        stall_req
);

   localparam int Depth = 2**ADDR_W;

   logic [DATA_W-1:0] mem [Depth];
   logic [NUM_RD-1:0] port_hazard;

   // Storage: cleared while rst is high, WB write at the edge, entry 0 never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         // NOTE: the array is reset on purpose: every entry must read 0 as soon as rst rises.
         for (int i = 0; i < Depth; i++) begin
            mem[i] <= DATA_W'(ZeroWord);
         end
      end else if (we == WriteEnable && waddr != ADDR_W'(NOPRegAddr)) begin
         // NOTE: sequential state uses non-blocking assignment so all reads see pre-edge values.
         mem[waddr] <= wdata;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rd_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .NUM_FWD (NUM_FWD)
      ) u_rd_port (
         .rst         (rst),
         .re          (re[k]),
         .raddr       (raddr[k*ADDR_W +: ADDR_W]),
         .mem_data    (mem[raddr[k*ADDR_W +: ADDR_W]]),
         .we          (we),
         .waddr       (waddr),
         .wdata       (wdata),
         .fwd_we      (fwd_we),
         .fwd_waddr   (fwd_waddr),
         .fwd_wdata   (fwd_wdata),
         .fwd_is_load (fwd_is_load),
         .rdata       (rdata[k*DATA_W +: DATA_W]),
         .hazard      (port_hazard[k])
      );
   end

   // Any port consuming a not-yet-loaded value stalls ID.
   assign stall_req = |port_hazard;

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed scenarios plus randomized
// traffic, compared against an array-based reference model.
module tb_regfile_fwd;
   import regfile_fwd_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NF = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [NR-1:0]    re;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NF-1:0]    fwd_we;
   logic [NF*AW-1:0] fwd_waddr;
   logic [NF*DW-1:0] fwd_wdata;
   logic [NF-1:0]    fwd_is_load;
   logic             stall_req;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model_mem [RegNum];

   regfile_fwd #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_FWD(NF)) dut (
      .clk         (clk),
      .rst         (rst),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .re          (re),
      .raddr       (raddr),
      .rdata       (rdata),
      .fwd_we      (fwd_we),
      .fwd_waddr   (fwd_waddr),
      .fwd_wdata   (fwd_wdata),
      .fwd_is_load (fwd_is_load),
      .stall_req   (stall_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference read: operand the ID stage should see on port k, and whether it is an unready load.
   task automatic model_read(input int k, output logic [DW-1:0] d, output logic ld);
      logic [AW-1:0] a;
      a  = raddr[k*AW +: AW];
      d  = '0;
      ld = 1'b0;
      if (rst || !re[k] || a == 0) return;
      for (int j = 0; j < NF; j++) begin
         if (fwd_we[j] && fwd_waddr[j*AW +: AW] == a) begin
            d  = fwd_wdata[j*DW +: DW];
            ld = fwd_is_load[j];
            return;
         end
      end
      if (we && waddr == a) d = wdata;
      else                  d = model_mem[a];
   endtask

   task automatic check_outputs(input string tag);
      logic [DW-1:0] d;
      logic ld;
      logic any_ld;
      any_ld = 1'b0;
      for (int k = 0; k < NR; k++) begin
         model_read(k, d, ld);
         any_ld |= ld;
         check($sformatf("%s_rdata%0d", tag, k), 64'(rdata[k*DW +: DW]), 64'(d));
      end
      check($sformatf("%s_stall", tag), 64'(stall_req), 64'(any_ld));
   endtask

   task automatic clear_model();
      for (int i = 0; i < RegNum; i++) model_mem[i] = '0;
   endtask

   // Called at a negedge with inputs set: check, commit the edge in the model, return at next negedge.
   task automatic cycle(input string tag);
      #1;
      if (rst) clear_model();
      check_outputs(tag);
      @(posedge clk);
      if (rst) clear_model();
      else if (we && waddr != 0) model_mem[waddr] = wdata;
      @(negedge clk);
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      re = '0; raddr = '0;
      fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
   endtask

   task automatic set_fwd(input int j, input logic en, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic ld);
      fwd_we[j]             = en;
      fwd_waddr[j*AW +: AW] = a;
      fwd_wdata[j*DW +: DW] = d;
      fwd_is_load[j]        = ld;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      clear_model();
      @(negedge clk);
      cycle("rst_init");
      rst = 1'b0;

      // Load every register with a distinct value.
      for (int i = 1; i < RegNum; i++) begin
         we = 1'b1; waddr = AW'(i); wdata = $urandom;
         cycle("load");
      end
      idle();

      // Write to r0 is discarded; both ports reading r0 see 0.
      we = 1'b1; waddr = '0; wdata = 32'hDEADBEEF;
      re = 2'b11; raddr = '0;
      #1;
      check("r0_port0", 64'(rdata[31:0]), 64'h0);
      check("r0_port1", 64'(rdata[63:32]), 64'h0);
      cycle("r0_write");
      idle();
      re = 2'b01; raddr = '0;
      cycle("r0_after");

      // Reset while loaded: everything reads back 0.
      rst = 1'b1;
      cycle("rst_loaded");
      rst = 1'b0;
      for (int i = 0; i < RegNum; i += 2) begin
         re = 2'b11; raddr = {AW'(i + 1), AW'(i)};
         #1;
         check("post_rst_even", 64'(rdata[31:0]), 64'h0);
         check("post_rst_odd", 64'(rdata[63:32]), 64'h0);
         cycle("post_rst");
      end
      idle();

      // Write r5, read it next cycle; port1 disabled on the same address.
      we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
      cycle("wr_r5");
      idle();
      re = 2'b01; raddr = {5'd5, 5'd5};
      #1;
      check("rd_r5", 64'(rdata[31:0]), 64'h1234_5678);
      check("rd_r5_disabled", 64'(rdata[63:32]), 64'h0);
      cycle("rd_r5");

      // Write-through in the same cycle.
      idle();
      we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
      re = 2'b01; raddr = {5'd0, 5'd7};
      #1;
      check("wthru_r7", 64'(rdata[31:0]), 64'hA5A5_A5A5);
      cycle("wthru_r7");

      // Forwarding priority on r9.
      idle();
      we = 1'b1; waddr = 5'd9; wdata = 32'd1;
      cycle("r9_init");
      wdata = 32'd2;
      re = 2'b01; raddr = {5'd0, 5'd9};
      set_fwd(1, 1'b1, 5'd9, 32'd3, 1'b0);
      set_fwd(0, 1'b1, 5'd9, 32'd4, 1'b0);
      #1; check("prio_ex", 64'(rdata[31:0]), 64'd4);
      cycle("prio_ex");
      set_fwd(0, 1'b0, 5'd9, 32'd4, 1'b0);
      #1; check("prio_mem", 64'(rdata[31:0]), 64'd3);
      cycle("prio_mem");
      set_fwd(1, 1'b0, 5'd9, 32'd3, 1'b0);
      #1; check("prio_wb", 64'(rdata[31:0]), 64'd2);
      cycle("prio_wb");

      // Load-use hazard, and masking of an older load by a younger ALU result.
      idle();
      re = 2'b10; raddr = {5'd3, 5'd0};
      set_fwd(0, 1'b1, 5'd3, 32'h0BAD_0003, 1'b1);
      #1; check("loaduse_stall", 64'(stall_req), 64'h1);
      cycle("loaduse");
      set_fwd(0, 1'b1, 5'd3, 32'h0000_C0DE, 1'b0);
      set_fwd(1, 1'b1, 5'd3, 32'h0BAD_0013, 1'b1);
      #1;
      check("masked_stall", 64'(stall_req), 64'h0);
      check("masked_rdata1", 64'(rdata[63:32]), 64'h0000_C0DE);
      cycle("masked");

      // Asynchronous reset between edges while a write to r12 is pending.
      idle();
      we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE_F00D;
      re = 2'b11; raddr = {5'd12, 5'd12};
      set_fwd(0, 1'b1, 5'd12, 32'h1111_2222, 1'b1);
      #1; check("pre_rst_stall", 64'(stall_req), 64'h1);
      #1; rst = 1'b1;
      #1;
      check("async_rdata0", 64'(rdata[31:0]), 64'h0);
      check("async_rdata1", 64'(rdata[63:32]), 64'h0);
      check("async_stall", 64'(stall_req), 64'h0);
      clear_model();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle();
      re = 2'b01; raddr = {5'd0, 5'd12};
      #1; check("r12_lost", 64'(rdata[31:0]), 64'h0);
      cycle("r12_lost");

      // Randomized traffic against the model; small address range to force collisions.
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 59) == 0);
         we    = 1'($urandom);
         waddr = AW'($urandom_range(0, 7));
         wdata = $urandom;
         re    = NR'($urandom);
         for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
         for (int j = 0; j < NF; j++)
            set_fwd(j, 1'($urandom), AW'($urandom_range(0, 7)), $urandom, 1'($urandom));
         cycle("rand");
      end
      rst = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
